// File: rtl/mem_rmw_pkg.sv
// Shared types and size encodings for the load/store responder and its lane merger.
package mem_rmw_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      READ    = 2'b01,
      CAPTURE = 2'b10,
      WRITE   = 2'b11
   } state_t;

   localparam logic [1:0] SIZE_WORD = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_BYTE = 2'b10;
   localparam logic [1:0] SIZE_RSVD = 2'b11;

   // The reserved encoding behaves exactly like a full word.
   function automatic logic is_word(input logic [1:0] size);
      return (size == SIZE_WORD) || (size == SIZE_RSVD);
   endfunction

endpackage

// File: rtl/mem_rmw_responder_lane_merge.sv
// Combinational little-endian lane merge: drops right-aligned store data into the addressed lane of an old word.
module lane_merge
   import mem_rmw_pkg::*;
(
   input  logic [31:0] old_word,
   input  logic [31:0] new_data,
   input  logic [1:0]  size,
   input  logic [1:0]  lane,
   output logic [31:0] merged
);

   always_comb begin
      merged = old_word;
      case (size)
         SIZE_HALF: begin
            if (lane[1])
               merged[31:16] = new_data[15:0];
            else
               merged[15:0] = new_data[15:0];
         end
         SIZE_BYTE: merged[{lane, 3'b000} +: 8] = new_data[7:0];
         default:   merged = new_data;
      endcase
   end

endmodule

// File: rtl/mem_rmw_responder.sv
// Word-RAM responder that turns halfword/byte stores into read-modify-write cycles.
// Optional build macro ALIGN_CHECK_EN flags misaligned requests through Error instead of masking them.
module mem_rmw_responder
   import mem_rmw_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              ReqValid,
   input  logic              Wr,
   input  logic [31:0]       Address,
   input  logic [31:0]       DataIn,
   input  logic [1:0]        Size,
   output logic [31:0]       DataOut,
   output logic              Done,
   output logic              Busy,
   output logic              Error,
   output logic [ADDR_W-1:0] MemAddr,
   output logic              MemWr,
   output logic [31:0]       MemWData,
   input  logic [31:0]       MemRData
);

   state_t              state, state_next;
   logic                wr_q, wr_next;
   logic [1:0]          size_q, size_next;
   logic [1:0]          lane_q, lane_next;
   logic [31:0]         data_q, data_next;
   logic [31:0]         dataout_next;
   logic                done_next;
   logic [ADDR_W-1:0]   memaddr_next;
   logic                memwr_next;
   logic [31:0]         memwdata_next;
   logic [31:0]         merged;
   logic [1:0]          lane_in;
   logic                misaligned;
   logic                unused_addr_bits;

   // Upper address bits simply wrap the access around the RAM.
   assign unused_addr_bits = ^Address[31:ADDR_W+2];
   assign Busy = (state != IDLE);

`ifdef ALIGN_CHECK_EN
   logic err_q, err_next, error_next;

   assign lane_in    = Address[1:0];
   assign misaligned = (Size == SIZE_HALF) ? Address[0] :
                       (Size == SIZE_BYTE) ? 1'b0 : (Address[1:0] != 2'b00);
`else
   // Misaligned low bits are dropped so the request lands on its natural boundary.
   assign lane_in    = (Size == SIZE_BYTE) ? Address[1:0] :
                       (Size == SIZE_HALF) ? {Address[1], 1'b0} : 2'b00;
   assign misaligned = 1'b0;
   assign Error      = 1'b0;
`endif

   lane_merge u_lane_merge (
      .old_word (MemRData),
      .new_data (data_q),
      .size     (size_q),
      .lane     (lane_q),
      .merged   (merged)
   );

   always_comb begin
      state_next    = state;
      wr_next       = wr_q;
      size_next     = size_q;
      lane_next     = lane_q;
      data_next     = data_q;
      dataout_next  = DataOut;
      done_next     = 1'b0;
      memaddr_next  = MemAddr;
      memwr_next    = 1'b0;
      memwdata_next = MemWData;
`ifdef ALIGN_CHECK_EN
      err_next      = err_q;
      error_next    = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (ReqValid) begin
               wr_next   = Wr;
               size_next = Size;
               lane_next = lane_in;
               data_next = DataIn;
`ifdef ALIGN_CHECK_EN
               err_next  = misaligned;
`endif
               // A misaligned request skips the RAM and just reports completion from WRITE.
               if (misaligned) begin
                  state_next = WRITE;
               end else begin
                  memaddr_next = Address[ADDR_W+1:2];
                  if (Wr && is_word(Size)) begin
                     memwdata_next = DataIn;
                     memwr_next    = 1'b1;
                     state_next    = WRITE;
                  end else begin
                     state_next = READ;
                  end
               end
            end
         end
         READ: state_next = CAPTURE;
         CAPTURE: begin
            if (wr_q) begin
               memwdata_next = merged;
               memwr_next    = 1'b1;
               state_next    = WRITE;
            end else begin
               dataout_next = MemRData;
               done_next    = 1'b1;
               state_next   = IDLE;
            end
         end
         WRITE: begin
            done_next  = 1'b1;
            state_next = IDLE;
`ifdef ALIGN_CHECK_EN
            error_next = err_q;
`endif
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state    <= IDLE;
         wr_q     <= 1'b0;
         size_q   <= SIZE_WORD;
         lane_q   <= 2'b00;
         data_q   <= '0;
         DataOut  <= '0;
         Done     <= 1'b0;
         MemAddr  <= '0;
         MemWr    <= 1'b0;
         MemWData <= '0;
`ifdef ALIGN_CHECK_EN
         err_q    <= 1'b0;
         Error    <= 1'b0;
`endif
      end else begin
         state    <= state_next;
         wr_q     <= wr_next;
         size_q   <= size_next;
         lane_q   <= lane_next;
         data_q   <= data_next;
         DataOut  <= dataout_next;
         Done     <= done_next;
         MemAddr  <= memaddr_next;
         MemWr    <= memwr_next;
         MemWData <= memwdata_next;
`ifdef ALIGN_CHECK_EN
         err_q    <= err_next;
         Error    <= error_next;
`endif
      end
   end

endmodule

// File: tb/tb_mem_rmw_responder.sv
// Self-checking bench for mem_rmw_responder with a behavioural 1-cycle-latency word RAM.
// Completions and RAM writes are checked against expectation queues filled as requests are issued.
module tb_mem_rmw_responder;
   import mem_rmw_pkg::*;

   localparam int ADDR_W = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic              reqValid;
   logic              wr;
   logic [31:0]       address;
   logic [31:0]       dataIn;
   logic [1:0]        size;
   logic [31:0]       dataOut;
   logic              done;
   logic              busy;
   logic              error;
   logic [ADDR_W-1:0] memAddr;
   logic              memWr;
   logic [31:0]       memWData;
   logic [31:0]       memRData;

   logic [31:0]       ram [0:2**ADDR_W-1];
   logic              preloadEn;
   logic [ADDR_W-1:0] preloadAddr;
   logic [31:0]       preloadData;

   typedef struct {
      string       tag;
      bit          isLoad;
      logic [31:0] data;
      logic        err;
   } doneExp_t;

   typedef struct {
      string             tag;
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wrExp_t;

   doneExp_t    doneQ[$];
   wrExp_t      wrQ[$];
   doneExp_t    dItem;
   wrExp_t      wItem;
   int          testCount = 0;
   int          failCount = 0;
   bit          monitorOn = 1'b0;
   logic [31:0] lastLoad = '0;
   int          lat;

   mem_rmw_responder #(.ADDR_W(ADDR_W)) dut (
      .Clk      (clk),
      .Reset    (reset),
      .ReqValid (reqValid),
      .Wr       (wr),
      .Address  (address),
      .DataIn   (dataIn),
      .Size     (size),
      .DataOut  (dataOut),
      .Done     (done),
      .Busy     (busy),
      .Error    (error),
      .MemAddr  (memAddr),
      .MemWr    (memWr),
      .MemWData (memWData),
      .MemRData (memRData)
   );

   always #5 clk = ~clk;

   // RAM model: preload port has priority so the bench can seed words while the DUT is idle.
   always @(posedge clk) begin
      if (preloadEn)
         ram[preloadAddr] <= preloadData;
      else if (memWr)
         ram[memAddr] <= memWData;
      memRData <= ram[memAddr];
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%h expected 0x%h", tag, observed, expected);
      end
   endtask

   task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
      @(negedge clk);
      preloadEn   = 1'b1;
      preloadAddr = a;
      preloadData = d;
      @(negedge clk);
      preloadEn   = 1'b0;
   endtask

   // Issues one request, holds ReqValid until Done and checks the completion latency in negedges.
   task automatic applyStimulus(input string tag, input bit isWr, input logic [31:0] addr,
                                input logic [31:0] data, input logic [1:0] sz, input bit expWrite,
                                input logic [31:0] expWord, input bit expErr, input int expLat);
      int n = 0;
      doneQ.push_back('{tag, !isWr, expWord, expErr});
      if (expWrite)
         wrQ.push_back('{tag, addr[ADDR_W+1:2], expWord});
      if (!isWr)
         lastLoad = expWord;
      reqValid = 1'b1;
      wr       = isWr;
      address  = addr;
      dataIn   = data;
      size     = sz;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (i == 1)
            checkOutput({tag, "_busy"}, 32'(busy), 1);
         if (done) begin
            n = i;
            break;
         end
      end
      reqValid = 1'b0;
      checkOutput({tag, "_latency"}, n, expLat);
   endtask

   always @(negedge clk) begin
      if (monitorOn) begin
         if (done) begin
            checkOutput("done_expected", 32'(doneQ.size() > 0), 1);
            if (doneQ.size() > 0) begin
               dItem = doneQ.pop_front();
               if (dItem.isLoad)
                  checkOutput({dItem.tag, "_dataout"}, dataOut, dItem.data);
               checkOutput({dItem.tag, "_error"}, 32'(error), 32'(dItem.err));
            end
         end
         if (memWr) begin
            checkOutput("write_expected", 32'(wrQ.size() > 0), 1);
            if (wrQ.size() > 0) begin
               wItem = wrQ.pop_front();
               checkOutput({wItem.tag, "_memaddr"}, 32'(memAddr), 32'(wItem.addr));
               checkOutput({wItem.tag, "_memwdata"}, memWData, wItem.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset       = 1'b1;
      reqValid    = 1'b0;
      wr          = 1'b0;
      address     = '0;
      dataIn      = '0;
      size        = SIZE_WORD;
      preloadEn   = 1'b0;
      preloadAddr = '0;
      preloadData = '0;
      repeat (3) @(negedge clk);
      checkOutput("reset_dataout", dataOut, 0);
      checkOutput("reset_done", 32'(done), 0);
      checkOutput("reset_busy", 32'(busy), 0);
      checkOutput("reset_error", 32'(error), 0);
      checkOutput("reset_memaddr", 32'(memAddr), 0);
      checkOutput("reset_memwr", 32'(memWr), 0);
      checkOutput("reset_memwdata", memWData, 0);
      reset     = 1'b0;
      monitorOn = 1'b1;

      preload(8'd4, 32'hAABBCCDD);
      preload(8'd5, 32'h5555AAAA);
      applyStimulus("word_store", 1'b1, 32'h10, 32'hDEADBEEF, SIZE_WORD, 1'b1, 32'hDEADBEEF, 1'b0, 2);
      applyStimulus("word_load", 1'b0, 32'h10, 32'h0, SIZE_WORD, 1'b0, 32'hDEADBEEF, 1'b0, 3);

      preload(8'd4, 32'hAABBCCDD);
      applyStimulus("byte_lane3", 1'b1, 32'h13, 32'hABCDEF11, SIZE_BYTE, 1'b1, 32'h11BBCCDD, 1'b0, 4);
      checkOutput("byte_lane3_ram", ram[4], 32'h11BBCCDD);
      preload(8'd4, 32'hAABBCCDD);
      applyStimulus("byte_lane0", 1'b1, 32'h10, 32'h00000022, SIZE_BYTE, 1'b1, 32'hAABBCC22, 1'b0, 4);
      preload(8'd4, 32'hAABBCCDD);
      applyStimulus("byte_lane1", 1'b1, 32'h11, 32'h00000033, SIZE_BYTE, 1'b1, 32'hAABB33DD, 1'b0, 4);
      preload(8'd4, 32'hAABBCCDD);
      applyStimulus("byte_lane2", 1'b1, 32'h12, 32'h00000044, SIZE_BYTE, 1'b1, 32'hAA44CCDD, 1'b0, 4);
      preload(8'd4, 32'hAABBCCDD);
      applyStimulus("half_hi", 1'b1, 32'h12, 32'hFFFF1234, SIZE_HALF, 1'b1, 32'h1234CCDD, 1'b0, 4);
      preload(8'd4, 32'hAABBCCDD);
      applyStimulus("half_lo", 1'b1, 32'h10, 32'h00001234, SIZE_HALF, 1'b1, 32'hAABB1234, 1'b0, 4);

      preload(8'd4, 32'hAABBCCDD);
`ifdef ALIGN_CHECK_EN
      applyStimulus("half_misaligned", 1'b1, 32'h11, 32'h00001234, SIZE_HALF, 1'b0, 32'h0, 1'b1, 2);
      checkOutput("half_misaligned_ram", ram[4], 32'hAABBCCDD);
      checkOutput("half_misaligned_dataout", dataOut, lastLoad);
      applyStimulus("word_misaligned", 1'b1, 32'h13, 32'hDEADBEEF, SIZE_WORD, 1'b0, 32'h0, 1'b1, 2);
      checkOutput("word_misaligned_ram", ram[4], 32'hAABBCCDD);
`else
      applyStimulus("half_masked", 1'b1, 32'h11, 32'h00001234, SIZE_HALF, 1'b1, 32'hAABB1234, 1'b0, 4);
      checkOutput("half_masked_ram", ram[4], 32'hAABB1234);
      applyStimulus("word_masked", 1'b1, 32'h13, 32'hDEADBEEF, SIZE_WORD, 1'b1, 32'hDEADBEEF, 1'b0, 2);
      checkOutput("word_masked_ram", ram[4], 32'hDEADBEEF);
`endif

      applyStimulus("wrap_store", 1'b1, 32'hFFFFFC10, 32'hCAFEF00D, SIZE_WORD, 1'b1, 32'hCAFEF00D, 1'b0, 2);
      applyStimulus("wrap_load", 1'b0, 32'h00000410, 32'h0, SIZE_WORD, 1'b0, 32'hCAFEF00D, 1'b0, 3);
      applyStimulus("rsvd_store", 1'b1, 32'h10, 32'h01020304, SIZE_RSVD, 1'b1, 32'h01020304, 1'b0, 2);
      checkOutput("rsvd_store_ram", ram[4], 32'h01020304);

      // Handshake: address wanders while busy, then a back-to-back load rides the Done cycle.
      preload(8'd4, 32'hAABBCCDD);
      doneQ.push_back('{"hs_first", 1'b1, 32'hAABBCCDD, 1'b0});
      doneQ.push_back('{"hs_second", 1'b1, 32'h5555AAAA, 1'b0});
      reqValid = 1'b1;
      wr       = 1'b0;
      size     = SIZE_WORD;
      address  = 32'h10;
      lat      = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (done) begin
            lat = i;
            break;
         end
         address = 32'h20 + 32'(i * 4);
      end
      checkOutput("hs_first_latency", lat, 3);
      checkOutput("hs_done_cycle_busy", 32'(busy), 0);
      address = 32'h14;
      @(negedge clk);
      checkOutput("hs_second_busy", 32'(busy), 1);
      lat = 0;
      for (int i = 2; i <= 20; i++) begin
         @(negedge clk);
         if (done) begin
            lat = i;
            break;
         end
      end
      reqValid = 1'b0;
      lastLoad = 32'h5555AAAA;
      checkOutput("hs_second_latency", lat, 3);

      // Reset in CAPTURE of a byte store must leave the RAM untouched.
      preload(8'd4, 32'hAABBCCDD);
      reqValid = 1'b1;
      wr       = 1'b1;
      address  = 32'h11;
      dataIn   = 32'h00000099;
      size     = SIZE_BYTE;
      @(negedge clk);
      reqValid = 1'b0;
      @(negedge clk);
      checkOutput("rst_capture_busy", 32'(busy), 1);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("rst_memwr", 32'(memWr), 0);
      checkOutput("rst_done", 32'(done), 0);
      checkOutput("rst_busy", 32'(busy), 0);
      checkOutput("rst_dataout", dataOut, 0);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_ram_intact", ram[4], 32'hAABBCCDD);
      applyStimulus("post_rst_load", 1'b0, 32'h10, 32'h0, SIZE_WORD, 1'b0, 32'hAABBCCDD, 1'b0, 3);

      repeat (2) @(negedge clk);
      checkOutput("doneq_drained", doneQ.size(), 0);
      checkOutput("wrq_drained", wrQ.size(), 0);
      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/mem_rmw_responder.md
Name: mem_rmw_responder

Overview:
- Memory-side responder for the multicycle CPU's load/store traffic.
- Accepts word, halfword and byte requests and returns the full 32-bit read word; the CPU-side load slicer extracts the lane.
- Converts halfword and byte stores into read-modify-write cycles on a word-wide synchronous RAM with 1-cycle read latency.
- Sits between the CPU address/data mux outputs and the RAM macro.

Parameters:
ADDR_W, 8, RAM word-address width. RAM depth = 2**ADDR_W words.

Ports:
Clk  in  1  clock; all state changes on the rising edge.
Reset  in  1  synchronous, active-high reset.
ReqValid  in  1  request strobe; sampled only in IDLE.
Wr  in  1  1 = store, 0 = load.
Address  in  32  byte address. Bits [ADDR_W+1:2] select the word; bits [1:0] select the lane.
DataIn  in  32  store data, right-aligned: byte in [7:0], halfword in [15:0].
Size  in  2  00 = word, 01 = halfword, 10 = byte, 11 = reserved (treated as word).
DataOut  out  32  read word. Holds its value until the next completed load.
Done  out  1  one-cycle completion pulse.
Busy  out  1  high whenever state != IDLE.
Error  out  1  misalign pulse, coincident with Done. Present only with ALIGN_CHECK_EN; otherwise tied 0.
MemAddr  out  ADDR_W  registered word address to the RAM.
MemWr  out  1  registered RAM write enable.
MemWData  out  32  registered RAM write data.
MemRData  in  32  RAM read data, valid the cycle after MemAddr is sampled.

Behaviour:
Reset:
- State -> IDLE.
- DataOut, Done, Busy, Error, MemAddr, MemWr, MemWData all 0.
- A reset in any state aborts the operation. MemWr is 0 after that edge, so no partial write reaches the RAM.

Encoding:
- Little-endian lanes.
- Byte lane = Address[1:0]; lane 0 is bits [7:0].
- Halfword lane = Address[1]; lane 0 is bits [15:0].

FSM states: IDLE, READ, CAPTURE, WRITE.
- IDLE:
  - On ReqValid, latch Address, DataIn, Size, Wr, and load MemAddr <= Address[ADDR_W+1:2].
  - Word store: MemWData <= DataIn, MemWr <= 1, go to WRITE.
  - Otherwise go to READ.
- READ: the RAM samples MemAddr. Go to CAPTURE.
- CAPTURE:
  - Load: DataOut <= MemRData, Done <= 1, go to IDLE.
  - Sub-word store: MemWData <= MemRData with the addressed lane replaced by DataIn[7:0] or DataIn[15:0]; MemWr <= 1; go to WRITE.
- WRITE: the RAM writes. Then MemWr <= 0, Done <= 1, go to IDLE.

Latency, with the request sampled at edge E0:
- Word store: Done is high after E1.
- Load: Done is high and DataOut is valid after E2.
- Sub-word store: Done is high after E3.

Handshake:
- ReqValid is ignored while Busy. The requester holds ReqValid until it sees Done.
- Done is high for exactly one cycle.
- A new request presented in the cycle Done is high is accepted; Busy is low in that cycle.
- Loads and stores never overlap, so a store followed by a load to the same word returns the new data.

Address boundary:
- Address bits above ADDR_W+1 are ignored, so addresses wrap modulo the RAM size.

Optional Feature:
Macro: ALIGN_CHECK_EN
- Defined:
  - A word request with Address[1:0] != 0, or a halfword request with Address[0] = 1, is misaligned.
  - A misaligned request goes IDLE -> WRITE with MemWr held 0.
  - After E1, Done = 1 and Error = 1.
  - No RAM access occurs and DataOut is unchanged.
- Undefined:
  - No Error port logic; the port is tied 0.
  - Misaligned low bits are masked: word forces [1:0] = 0, halfword forces [0] = 0. The request then proceeds normally.

Decomposition:
- Package mem_rmw_pkg holds:
  - state enum (IDLE, READ, CAPTURE, WRITE);
  - size constants SIZE_WORD = 2'b00, SIZE_HALF = 2'b01, SIZE_BYTE = 2'b10.
- Sub-module lane_merge: combinational. Inputs are old word, new data, Size and Address[1:0]; output is the merged word. It is used in CAPTURE and unit-tested alone.

Test Plan:
All scenarios start with RAM word 4 (byte address 0x10) = 0xAABBCCDD.
1. Word store 0xDEADBEEF to 0x10 -> MemAddr = 4 and MemWr = 1 for one cycle; Done after E1. A following load of 0x10 returns DataOut = 0xDEADBEEF after E2 of the load.
2. Sub-word stores, each from the initial RAM value:
   - byte 0x11 to 0x13 -> MemWData = 0x11BBCCDD; Done after E3.
   - byte 0x22 to 0x10 -> MemWData = 0xAABBCC22.
3. Halfword stores, each from the initial RAM value:
   - 0x1234 to 0x12 -> MemWData = 0x1234CCDD.
   - 0x1234 to 0x10 -> MemWData = 0xAABB1234.
4. Halfword store to 0x11:
   - With ALIGN_CHECK_EN: Done = 1 and Error = 1 after E1; MemWr never asserted; RAM still 0xAABBCCDD.
   - Without it: behaves exactly as a store to 0x10.
5. Handshake:
   - ReqValid held high with changing Address while Busy -> ignored.
   - A second load presented in the Done cycle is accepted, with Busy rising at the next edge.
6. Reset asserted during CAPTURE of a byte store -> next cycle state IDLE, MemWr = 0, Done = 0; RAM word stays 0xAABBCCDD.
